sha_job_dispatcher: RTL and testbench
=====================================

# sha_job_dispatcher

Job-side front end for the `sha_hasher` mining core. It deserializes a 20-word mining job from a 32-bit valid/ready stream and loads it into the hasher. It then arms the hasher with a one-cycle load pulse, streams `write_en` while nonces are searched, and drains the pipeline. It converts the hasher's live counter into the real solution `{time,nonce}` by subtracting the pipeline lag, and queues solutions in a small FIFO for the host link.

## Interface
- `RESULT_LAG`, 128: number of `write_en` cycles between a nonce entering the hasher and its `valid_out`.
- `FIFO_DEPTH`, 4: result FIFO entries; must be a power of 2, at least 2.
- `CLK` in 1: clock; all logic is on the rising edge.
- `RST` in 1: asynchronous, active-low reset.
- `job_valid` in 1: job word valid.
- `job_data` in 32: job word.
- `job_ready` out 1: job word accepted when `job_valid && job_ready`.
- `abort` in 1: discards the current job or load.
- `hs_rst_n` out 1: registered load/reset pulse to the hasher's `RST`.
- `hs_write_en` out 1: hasher advance enable.
- `hs_digest_intial` out 256, `hs_digest_in` out 256: midstate operands.
- `hs_merkle` out 32, `hs_time` out 32, `hs_target` out 32, `hs_nonce` out 32: block operands.
- `hs_valid` in 1: hasher `valid_out`.
- `hs_time_cnt` in 32, `hs_nonce_cnt` in 32: hasher `time_out`, `nonce_out`.
- `res_valid` out 1, `res_ready` in 1: result handshake.
- `res_time` out 32, `res_nonce` out 32: solution values.
- `busy` out 1: high whenever state is not IDLE.
- `overflow` out 1: sticky flag, set when a result is dropped.

## Operation
- Job word order is 0–7 `digest_intial` (word 0 = bits 255:224), 8–15 `digest_in` (same order), 16 merkle, 17 time, 18 target, 19 nonce.
- FSM states: IDLE, LOAD, ARM, RUN, DRAIN.
  - IDLE → LOAD on the first accepted word. `overflow` clears on that word.
  - LOAD → ARM on acceptance of word 19.
  - ARM lasts exactly one cycle, then goes to RUN.
  - RUN → DRAIN when `hs_write_en=1` and `hs_nonce_cnt==32'hFFFFFFFF`.
  - DRAIN → IDLE after RESULT_LAG further `write_en` cycles.
- `job_ready` = (state IDLE or LOAD) and `!abort`; it is 0 while RST is low.
- Word counter is 5 bits and counts 0..19. Each accepted word writes its field directly into the `hs_*` register.
- `hs_*` operands stay stable from ARM until the next LOAD word overwrites them.
- `hs_rst_n` is 0 during ARM only (and while RST is low). This reloads the hasher's nonce/time counters from `hs_nonce`/`hs_time`.
- `hs_write_en` is 1 in RUN and DRAIN, and 0 otherwise.
- Warm-up counter: in RUN, `hs_valid` is ignored until RESULT_LAG `write_en` cycles have elapsed since ARM. DRAIN is always past warm-up.
- Result capture: when `hs_valid=1` in RUN (past warm-up) or DRAIN, push `{hs_time_cnt,hs_nonce_cnt} − RESULT_LAG` into the FIFO.
  - The subtraction is 64-bit and wraps modulo 2^64; borrow propagates into time.
- FIFO full with a push and no pop: the result is dropped and `overflow` is set. Push and pop in the same cycle while full: both occur, nothing is dropped.
- `abort` in LOAD, RUN or DRAIN → IDLE next cycle. The word counter clears; `hs_write_en` is 0 from the next cycle. FIFO contents and `overflow` are retained.
- `abort` in IDLE has no effect. `abort` during ARM → IDLE; the ARM pulse is already issued.

## Timing
- Reset values:
  - all `hs_*` data = 0, `hs_rst_n`=0, `hs_write_en`=0
  - `res_valid`=0, `res_time`=`res_nonce`=0
  - `busy`=0, `overflow`=0, FIFO empty, state IDLE
- Word 19 accepted at cycle N → ARM at N+1 (`hs_rst_n`=0) → RUN at N+2 (`hs_write_en`=1).
- Capture latency: `hs_valid` sampled at cycle K → `res_valid`=1 at K+1 if the FIFO was empty.
- FIFO is first-word-fall-through. `res_time`/`res_nonce` are valid whenever `res_valid`=1 and are held until `res_ready`.
- `busy` is registered from state and asserts the cycle after the first accepted word.

## Test plan
- Job load: stream 20 words with nonce=0x00000010, time=0x5000_0000 and no backpressure. Then `hs_rst_n`=0 exactly one cycle at N+1, `hs_write_en`=1 from N+2, and all `hs_*` fields match the words.
- Lag correction: at `hs_nonce_cnt`=0x00000090, `hs_time_cnt`=0x5000_0000 with RESULT_LAG=128, pulse `hs_valid` → result {0x5000_0000, 0x00000010}. At `hs_nonce_cnt`=0x00000005, time 0x5000_0001 → result {0x5000_0000, 0xFFFFFF85}.
- Warm-up/drain: `hs_valid` at 10 cycles after ARM → ignored. After `hs_nonce_cnt` reaches 0xFFFFFFFF, exactly 128 DRAIN cycles follow, then `busy`=0.
- FIFO overflow: hold `res_ready`=0 and send 5 valid hits with depth 4 → 4 results are retained in order and `overflow`=1. A push and pop in the same cycle while full drops nothing.
- Abort: assert `abort` together with `job_valid` at word 7 → word not accepted, IDLE, counter restarts at word 0. Assert `abort` in RUN → `hs_write_en`=0 next cycle and the FIFO is kept.
- Async reset: assert RST low mid-RUN → outputs reach reset values immediately and `hs_rst_n`=0. After release, `job_ready`=1.

Source files
------------

// File: rtl/sha_job_dispatcher.sv
// sha_job_dispatcher: job-side front end for the sha_hasher mining core.
// Deserializes a 20-word job into the hasher operand registers, arms the
// hasher with a one-cycle load pulse, streams write_en while nonces are
// searched, drains the pipeline, and queues lag-corrected solutions.
//
// Ports:
//   CLK, RST            clock, asynchronous active-low reset
//   job_valid/ready     32-bit job word stream (job_data)
//   abort               discards the current job or load
//   hs_rst_n            registered load pulse to the hasher (low in ARM)
//   hs_write_en         hasher advance enable (RUN and DRAIN)
//   hs_digest_intial, hs_digest_in, hs_merkle, hs_time, hs_target, hs_nonce
//                       hasher operands
//   hs_valid, hs_time_cnt, hs_nonce_cnt
//                       hasher valid_out and live counters
//   res_valid/ready     solution handshake, res_time/res_nonce payload
//   busy                state is not IDLE (registered)
//   overflow            sticky, a solution was dropped on a full FIFO
module sha_job_dispatcher #(
  parameter int unsigned RESULT_LAG = 128,
  parameter int unsigned FIFO_DEPTH = 4
) (
  input  logic         CLK,
  input  logic         RST,
  input  logic         job_valid,
  input  logic [31:0]  job_data,
  output logic         job_ready,
  input  logic         abort,
  output logic         hs_rst_n,
  output logic         hs_write_en,
  output logic [255:0] hs_digest_intial,
  output logic [255:0] hs_digest_in,
  output logic [31:0]  hs_merkle,
  output logic [31:0]  hs_time,
  output logic [31:0]  hs_target,
  output logic [31:0]  hs_nonce,
  input  logic         hs_valid,
  input  logic [31:0]  hs_time_cnt,
  input  logic [31:0]  hs_nonce_cnt,
  output logic         res_valid,
  input  logic         res_ready,
  output logic [31:0]  res_time,
  output logic [31:0]  res_nonce,
  output logic         busy,
  output logic         overflow
);

  localparam int unsigned LAST_WORD = 19;
  localparam int unsigned LAG_W     = $clog2(RESULT_LAG + 1);
  localparam int unsigned AW        = $clog2(FIFO_DEPTH);
  localparam int unsigned CW        = AW + 1;

  typedef enum logic [2:0] {IDLE, LOAD, ARM, RUN, DRAIN} state_t;

  state_t           state, state_next;
  logic [4:0]       word_cnt;
  logic [LAG_W-1:0] lag_cnt;
  logic             rst_n_d, write_en_d, busy_d;
  logic             accept, warm, capture;
  logic [63:0]      cap_val;

  logic [63:0]      mem [FIFO_DEPTH];
  logic [AW-1:0]    rd_ptr, wr_ptr;
  logic [CW-1:0]    count, count_next, count_after_pop;
  logic             pop, push, drop, full;

  assign job_ready = RST && ((state == IDLE) || (state == LOAD)) && !abort;
  assign accept    = job_valid && job_ready;
  // Saturates at RESULT_LAG: that many write_en cycles have passed since ARM.
  assign warm      = (lag_cnt == LAG_W'(RESULT_LAG));
  assign capture   = hs_valid && (((state == RUN) && warm) || (state == DRAIN));
  // Live counters run RESULT_LAG ahead of the nonce that produced valid_out.
  assign cap_val   = {hs_time_cnt, hs_nonce_cnt} - 64'(RESULT_LAG);

  // Next-state and registered-output decode.
  always_comb begin
    state_next = state;
    rst_n_d    = 1'b1;
    write_en_d = 1'b0;
    busy_d     = 1'b0;
    case (state)
      IDLE:  if (accept) state_next = LOAD;
      LOAD: begin
        if (abort) state_next = IDLE;
        else if (accept && (word_cnt == 5'(LAST_WORD))) state_next = ARM;
      end
      ARM:   state_next = abort ? IDLE : RUN;
      RUN: begin
        if (abort) state_next = IDLE;
        else if (hs_write_en && (hs_nonce_cnt == 32'hFFFF_FFFF)) state_next = DRAIN;
      end
      DRAIN: begin
        if (abort) state_next = IDLE;
        else if (lag_cnt == LAG_W'(RESULT_LAG - 1)) state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
    rst_n_d    = (state_next != ARM);
    write_en_d = (state_next == RUN) || (state_next == DRAIN);
    busy_d     = (state_next != IDLE);
  end

  // State and control output registers.
  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      state       <= IDLE;
      hs_rst_n    <= 1'b0;
      hs_write_en <= 1'b0;
      busy        <= 1'b0;
    end else begin
      state       <= state_next;
      hs_rst_n    <= rst_n_d;
      hs_write_en <= write_en_d;
      busy        <= busy_d;
    end
  end

  // Word counter; also restarts at word 0 on abort.
  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      word_cnt <= 5'd0;
    end else if (accept) begin
      word_cnt <= (word_cnt == 5'(LAST_WORD)) ? 5'd0 : word_cnt + 5'd1;
    end else if (abort) begin
      word_cnt <= 5'd0;
    end
  end

  // Each accepted word lands directly in its operand field.
  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      hs_digest_intial <= '0;
      hs_digest_in     <= '0;
      hs_merkle        <= '0;
      hs_time          <= '0;
      hs_target        <= '0;
      hs_nonce         <= '0;
    end else if (accept) begin
      for (int i = 0; i < 8; i++) begin
        if (word_cnt == 5'(i))     hs_digest_intial[255-32*i -: 32] <= job_data;
        if (word_cnt == 5'(i + 8)) hs_digest_in[255-32*i -: 32]     <= job_data;
      end
      if (word_cnt == 5'd16) hs_merkle <= job_data;
      if (word_cnt == 5'd17) hs_time   <= job_data;
      if (word_cnt == 5'd18) hs_target <= job_data;
      if (word_cnt == 5'd19) hs_nonce  <= job_data;
    end
  end

  // Lag counter: warm-up in RUN, restarted on entry to DRAIN as its length.
  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      lag_cnt <= '0;
    end else if ((state_next == ARM) || ((state_next == DRAIN) && (state != DRAIN))) begin
      lag_cnt <= '0;
    end else if (hs_write_en && !warm) begin
      lag_cnt <= lag_cnt + LAG_W'(1);
    end
  end

  // Result FIFO, first-word-fall-through with a registered head.
  assign pop             = res_valid && res_ready;
  assign full            = (count == CW'(FIFO_DEPTH));
  assign push            = capture && (!full || pop);
  assign drop            = capture && full && !pop;
  assign count_after_pop = count - CW'(pop);
  assign count_next      = count_after_pop + CW'(push);

  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      for (int i = 0; i < int'(FIFO_DEPTH); i++) mem[i] <= '0;
      rd_ptr    <= '0;
      wr_ptr    <= '0;
      count     <= '0;
      res_valid <= 1'b0;
      res_time  <= '0;
      res_nonce <= '0;
    end else begin
      if (push) begin
        mem[wr_ptr] <= cap_val;
        wr_ptr      <= wr_ptr + AW'(1);
      end
      if (pop) rd_ptr <= rd_ptr + AW'(1);
      count     <= count_next;
      res_valid <= (count_next != '0);
      // Head comes from the push itself when nothing older remains.
      if (count_after_pop == '0) begin
        if (push) {res_time, res_nonce} <= cap_val;
      end else if (pop) begin
        {res_time, res_nonce} <= mem[rd_ptr + AW'(1)];
      end
    end
  end

  // Sticky drop flag, cleared by the first word of the next job.
  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      overflow <= 1'b0;
    end else if (drop) begin
      overflow <= 1'b1;
    end else if (accept && (state == IDLE)) begin
      overflow <= 1'b0;
    end
  end

endmodule

// File: tb/tb_sha_job_dispatcher.sv
// Directed self-checking bench for sha_job_dispatcher.
module tb_sha_job_dispatcher;

  logic         CLK;
  logic         RST;
  logic         job_valid;
  logic [31:0]  job_data;
  logic         job_ready;
  logic         abort;
  logic         hs_rst_n;
  logic         hs_write_en;
  logic [255:0] hs_digest_intial;
  logic [255:0] hs_digest_in;
  logic [31:0]  hs_merkle, hs_time, hs_target, hs_nonce;
  logic         hs_valid;
  logic [31:0]  hs_time_cnt, hs_nonce_cnt;
  logic         res_valid, res_ready;
  logic [31:0]  res_time, res_nonce;
  logic         busy, overflow;

  int checks;
  int errors;
  logic [31:0] job_w [20];

  sha_job_dispatcher #(.RESULT_LAG(128), .FIFO_DEPTH(4)) dut (
    .CLK(CLK), .RST(RST),
    .job_valid(job_valid), .job_data(job_data), .job_ready(job_ready),
    .abort(abort),
    .hs_rst_n(hs_rst_n), .hs_write_en(hs_write_en),
    .hs_digest_intial(hs_digest_intial), .hs_digest_in(hs_digest_in),
    .hs_merkle(hs_merkle), .hs_time(hs_time), .hs_target(hs_target), .hs_nonce(hs_nonce),
    .hs_valid(hs_valid), .hs_time_cnt(hs_time_cnt), .hs_nonce_cnt(hs_nonce_cnt),
    .res_valid(res_valid), .res_ready(res_ready),
    .res_time(res_time), .res_nonce(res_nonce),
    .busy(busy), .overflow(overflow)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  task automatic fill_job(input logic [31:0] seed, input logic [31:0] t, input logic [31:0] n);
    for (int i = 0; i < 20; i++) job_w[i] = seed + 32'(i) * 32'h0101_0101;
    job_w[17] = t;
    job_w[19] = n;
  endtask

  task automatic stream_words(input int last);
    for (int i = 0; i <= last; i++) begin
      job_valid = 1'b1;
      job_data  = job_w[i];
      tick();
    end
    job_valid = 1'b0;
  endtask

  task automatic test_reset();
    RST = 1'b0; job_valid = 1'b0; job_data = '0; abort = 1'b0;
    hs_valid = 1'b0; hs_time_cnt = '0; hs_nonce_cnt = '0; res_ready = 1'b0;
    #2;
    checks++; if (hs_rst_n !== 1'b0) begin errors++; $display("FAIL reset_hs_rst_n: got %b expected 0", hs_rst_n); end
    checks++; if (hs_write_en !== 1'b0 || busy !== 1'b0 || overflow !== 1'b0 || res_valid !== 1'b0) begin
      errors++; $display("FAIL reset_flags: got we=%b busy=%b ovf=%b rv=%b expected all 0", hs_write_en, busy, overflow, res_valid); end
    checks++; if (hs_nonce !== 32'h0 || hs_digest_intial !== 256'h0 || res_time !== 32'h0 || res_nonce !== 32'h0) begin
      errors++; $display("FAIL reset_data: got nonce=%h res=%h_%h expected 0", hs_nonce, res_time, res_nonce); end
    checks++; if (job_ready !== 1'b0) begin errors++; $display("FAIL reset_job_ready: got %b expected 0", job_ready); end
    repeat (2) @(posedge CLK);
    #1; RST = 1'b1; #1;
    checks++; if (job_ready !== 1'b1) begin errors++; $display("FAIL release_job_ready: got %b expected 1", job_ready); end
    tick();
    checks++; if (hs_rst_n !== 1'b1 || busy !== 1'b0) begin
      errors++; $display("FAIL release_idle: got hs_rst_n=%b busy=%b expected 1 0", hs_rst_n, busy); end
  endtask

  task automatic test_job_load();
    logic [255:0] exp_di, exp_dn;
    fill_job(32'hA000_0000, 32'h5000_0000, 32'h0000_0010);
    for (int i = 0; i < 8; i++) begin
      exp_di[255-32*i -: 32] = job_w[i];
      exp_dn[255-32*i -: 32] = job_w[i+8];
    end
    job_valid = 1'b1; job_data = job_w[0];
    tick();
    checks++; if (busy !== 1'b1) begin errors++; $display("FAIL load_busy: got %b expected 1", busy); end
    checks++; if (hs_digest_intial[255:224] !== job_w[0]) begin
      errors++; $display("FAIL load_word0: got %h expected %h", hs_digest_intial[255:224], job_w[0]); end
    checks++; if (job_ready !== 1'b1) begin errors++; $display("FAIL load_ready: got %b expected 1", job_ready); end
    for (int i = 1; i < 20; i++) begin
      job_data = job_w[i];
      tick();
    end
    job_valid = 1'b0;
    checks++; if (hs_rst_n !== 1'b0 || hs_write_en !== 1'b0 || job_ready !== 1'b0) begin
      errors++; $display("FAIL arm_cycle: got rst_n=%b we=%b ready=%b expected 0 0 0", hs_rst_n, hs_write_en, job_ready); end
    tick();
    checks++; if (hs_rst_n !== 1'b1 || hs_write_en !== 1'b1) begin
      errors++; $display("FAIL run_entry: got rst_n=%b we=%b expected 1 1", hs_rst_n, hs_write_en); end
    checks++; if (hs_digest_intial !== exp_di || hs_digest_in !== exp_dn) begin
      errors++; $display("FAIL load_digests: got %h %h expected %h %h", hs_digest_intial, hs_digest_in, exp_di, exp_dn); end
    checks++; if (hs_merkle !== job_w[16] || hs_time !== 32'h5000_0000 || hs_target !== job_w[18] || hs_nonce !== 32'h0000_0010) begin
      errors++; $display("FAIL load_fields: got %h %h %h %h expected %h 50000000 %h 00000010", hs_merkle, hs_time, hs_target, hs_nonce, job_w[16], job_w[18]); end
  endtask

  // Entered at RUN cycle 1.
  task automatic test_warmup_lag();
    for (int r = 1; r < 10; r++) tick();
    hs_valid = 1'b1; hs_time_cnt = 32'h5000_0000; hs_nonce_cnt = 32'h0000_0019;
    tick();
    hs_valid = 1'b0;
    checks++; if (res_valid !== 1'b0) begin errors++; $display("FAIL warmup_early_hit: got res_valid=%b expected 0", res_valid); end
    for (int r = 11; r < 128; r++) tick();
    hs_valid = 1'b1; hs_nonce_cnt = 32'h0000_008F;
    tick();
    checks++; if (res_valid !== 1'b0) begin errors++; $display("FAIL warmup_last_cycle: got res_valid=%b expected 0", res_valid); end
    hs_nonce_cnt = 32'h0000_0090;
    tick();
    hs_valid = 1'b0;
    checks++; if (res_valid !== 1'b1 || res_time !== 32'h5000_0000 || res_nonce !== 32'h0000_0010) begin
      errors++; $display("FAIL lag_basic: got v=%b %h_%h expected 1 50000000_00000010", res_valid, res_time, res_nonce); end
    res_ready = 1'b1;
    hs_valid = 1'b1; hs_time_cnt = 32'h5000_0001; hs_nonce_cnt = 32'h0000_0005;
    tick();
    hs_valid = 1'b0;
    checks++; if (res_valid !== 1'b1 || res_time !== 32'h5000_0000 || res_nonce !== 32'hFFFF_FF85) begin
      errors++; $display("FAIL lag_borrow: got v=%b %h_%h expected 1 50000000_ffffff85", res_valid, res_time, res_nonce); end
    tick();
    checks++; if (res_valid !== 1'b0) begin errors++; $display("FAIL lag_drained: got res_valid=%b expected 0", res_valid); end
    res_ready = 1'b0;
  endtask

  task automatic test_fifo_overflow();
    logic [31:0] exp_n [4];
    exp_n[0] = 32'h101; exp_n[1] = 32'h102; exp_n[2] = 32'h103; exp_n[3] = 32'h105;
    res_ready = 1'b0; hs_valid = 1'b1; hs_time_cnt = 32'h6000_0000;
    for (int i = 0; i < 5; i++) begin
      hs_nonce_cnt = 32'h180 + 32'(i);
      if (i == 4) begin
        checks++; if (overflow !== 1'b0) begin errors++; $display("FAIL ovf_before_drop: got %b expected 0", overflow); end
      end
      tick();
    end
    checks++; if (overflow !== 1'b1) begin errors++; $display("FAIL ovf_set: got %b expected 1", overflow); end
    checks++; if (res_valid !== 1'b1 || res_nonce !== 32'h100 || res_time !== 32'h6000_0000) begin
      errors++; $display("FAIL ovf_head: got v=%b %h_%h expected 1 60000000_00000100", res_valid, res_time, res_nonce); end
    hs_nonce_cnt = 32'h185; res_ready = 1'b1;
    tick();
    hs_valid = 1'b0;
    for (int k = 0; k < 4; k++) begin
      checks++; if (res_valid !== 1'b1 || res_nonce !== exp_n[k] || res_time !== 32'h6000_0000) begin
        errors++; $display("FAIL ovf_order%0d: got v=%b %h_%h expected 1 60000000_%h", k, res_valid, res_time, res_nonce, exp_n[k]); end
      tick();
    end
    checks++; if (res_valid !== 1'b0 || overflow !== 1'b1) begin
      errors++; $display("FAIL ovf_empty: got v=%b ovf=%b expected 0 1", res_valid, overflow); end
    res_ready = 1'b0;
  endtask

  task automatic test_drain();
    int n;
    hs_nonce_cnt = 32'hFFFF_FFFF;
    tick();
    n = 0;
    while (hs_write_en === 1'b1 && n < 300) begin
      n++;
      hs_valid = (n == 1); hs_time_cnt = 32'h0000_0007; hs_nonce_cnt = 32'h0000_0080;
      res_ready = (n == 2);
      if (n == 2) begin
        checks++; if (res_valid !== 1'b1 || res_time !== 32'h7 || res_nonce !== 32'h0) begin
          errors++; $display("FAIL drain_capture: got v=%b %h_%h expected 1 00000007_00000000", res_valid, res_time, res_nonce); end
      end
      tick();
    end
    hs_valid = 1'b0; res_ready = 1'b0;
    checks++; if (n !== 128) begin errors++; $display("FAIL drain_len: got %0d expected 128", n); end
    checks++; if (busy !== 1'b0 || res_valid !== 1'b0) begin
      errors++; $display("FAIL drain_idle: got busy=%b rv=%b expected 0 0", busy, res_valid); end
  endtask

  task automatic test_abort_load();
    logic [31:0]  a7;
    logic [255:0] exp_di, exp_dn;
    a7 = job_w[7];
    fill_job(32'hB000_0000, 32'h1111_1111, 32'h2222_2222);
    stream_words(6);
    checks++; if (overflow !== 1'b0) begin errors++; $display("FAIL abort_ovf_clear: got %b expected 0", overflow); end
    job_valid = 1'b1; job_data = job_w[7]; abort = 1'b1;
    #1;
    checks++; if (job_ready !== 1'b0) begin errors++; $display("FAIL abort_ready: got %b expected 0", job_ready); end
    tick();
    job_valid = 1'b0; abort = 1'b0;
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL abort_load_idle: got busy=%b expected 0", busy); end
    checks++; if (hs_digest_intial[31:0] !== a7) begin
      errors++; $display("FAIL abort_word7: got %h expected %h", hs_digest_intial[31:0], a7); end
    fill_job(32'hC000_0000, 32'h7000_0001, 32'h0000_0100);
    for (int i = 0; i < 8; i++) begin
      exp_di[255-32*i -: 32] = job_w[i];
      exp_dn[255-32*i -: 32] = job_w[i+8];
    end
    job_valid = 1'b1; job_data = job_w[0];
    tick();
    job_valid = 1'b0;
    checks++; if (hs_digest_intial[255:224] !== job_w[0] || hs_digest_intial[223:192] !== 32'hB101_0101) begin
      errors++; $display("FAIL abort_restart: got %h %h expected %h b1010101", hs_digest_intial[255:224], hs_digest_intial[223:192], job_w[0]); end
    for (int i = 1; i < 20; i++) begin
      job_valid = 1'b1; job_data = job_w[i];
      tick();
    end
    job_valid = 1'b0;
    checks++; if (hs_rst_n !== 1'b0 || hs_digest_intial !== exp_di || hs_digest_in !== exp_dn || hs_nonce !== 32'h100) begin
      errors++; $display("FAIL abort_reload: got rst_n=%b nonce=%h expected 0 00000100", hs_rst_n, hs_nonce); end
  endtask

  // Entered at the ARM cycle of the job loaded by test_abort_load.
  task automatic test_abort_run();
    tick();
    for (int r = 1; r < 129; r++) tick();
    hs_valid = 1'b1; hs_time_cnt = 32'h7000_0001; hs_nonce_cnt = 32'h0000_0003;
    tick();
    hs_valid = 1'b0; abort = 1'b1;
    tick();
    abort = 1'b0;
    checks++; if (hs_write_en !== 1'b0 || busy !== 1'b0) begin
      errors++; $display("FAIL abort_run: got we=%b busy=%b expected 0 0", hs_write_en, busy); end
    checks++; if (res_valid !== 1'b1 || res_time !== 32'h7000_0000 || res_nonce !== 32'hFFFF_FF83) begin
      errors++; $display("FAIL abort_keep_fifo: got v=%b %h_%h expected 1 70000000_ffffff83", res_valid, res_time, res_nonce); end
  endtask

  task automatic test_abort_arm();
    fill_job(32'hD000_0000, 32'h0000_0001, 32'h0000_0002);
    stream_words(19);
    checks++; if (hs_rst_n !== 1'b0) begin errors++; $display("FAIL abort_arm_pulse: got %b expected 0", hs_rst_n); end
    abort = 1'b1;
    tick();
    checks++; if (hs_rst_n !== 1'b1 || hs_write_en !== 1'b0 || busy !== 1'b0) begin
      errors++; $display("FAIL abort_arm: got rst_n=%b we=%b busy=%b expected 1 0 0", hs_rst_n, hs_write_en, busy); end
    abort = 1'b0;
    #1;
    checks++; if (job_ready !== 1'b1) begin errors++; $display("FAIL abort_arm_ready: got %b expected 1", job_ready); end
  endtask

  task automatic test_async_reset();
    fill_job(32'hE000_0000, 32'h0000_0003, 32'h0000_0004);
    stream_words(19);
    repeat (3) tick();
    checks++; if (hs_write_en !== 1'b1 || res_valid !== 1'b1) begin
      errors++; $display("FAIL pre_reset: got we=%b rv=%b expected 1 1", hs_write_en, res_valid); end
    #2; RST = 1'b0; #1;
    checks++; if (hs_write_en !== 1'b0 || hs_rst_n !== 1'b0 || busy !== 1'b0 || job_ready !== 1'b0) begin
      errors++; $display("FAIL async_ctrl: got we=%b rst_n=%b busy=%b ready=%b expected 0 0 0 0", hs_write_en, hs_rst_n, busy, job_ready); end
    checks++; if (res_valid !== 1'b0 || res_time !== 32'h0 || res_nonce !== 32'h0 || hs_nonce !== 32'h0 || hs_digest_in !== 256'h0) begin
      errors++; $display("FAIL async_data: got rv=%b %h_%h nonce=%h expected 0 0_0 0", res_valid, res_time, res_nonce, hs_nonce); end
    @(negedge CLK);
    RST = 1'b1;
    tick();
    checks++; if (job_ready !== 1'b1 || hs_rst_n !== 1'b1 || busy !== 1'b0) begin
      errors++; $display("FAIL post_reset: got ready=%b rst_n=%b busy=%b expected 1 1 0", job_ready, hs_rst_n, busy); end
  endtask

  initial begin
    checks = 0;
    errors = 0;
    test_reset();
    test_job_load();
    test_warmup_lag();
    test_fifo_overflow();
    test_drain();
    test_abort_load();
    test_abort_run();
    test_abort_arm();
    test_async_reset();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
